fb_scanout: RTL and testbench

//  Read side of the double-buffered framebuffer. Generates 640x480@60 VGA timing on the

---
 rtl/fb_scanout.sv | 244 ++++++++++++++++++++++++
 tb/tb_fb_scanout.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
//==============================================================================
// Module      : fb_scanout
// Description : Read side of a double-buffered framebuffer. Generates VGA
//               timing (640x480@60 by default) on the pixel clock, fetches
//               half-resolution RGB444 pixels from the front buffer with 2x
//               pixel and line doubling, and swaps front/back buffers at the
//               start of vblank when the renderer asks for it.
// Ports       :
//   clk         in   1       pixel clock
//   rst         in   1       synchronous active-high reset
//   rd_en       out  1       RAM read strobe (combinational, active region)
//   rd_addr     out  ADDR_W  RAM read address (0 outside the active region)
//   rd_data     in   12      RAM read data {R,G,B}, valid RD_LAT cycles later
//   swap_req    in   1       rising edge arms a buffer swap
//   swap_ack    out  1       one-cycle pulse: swap performed
//   back_buf    out  1       buffer index the renderer may write (~front)
//   frame_start out  1       one-cycle pulse after counters hold (0,0)
//   vga_hs      out  1       hsync, active low
//   vga_vs      out  1       vsync, active low
//   vga_de      out  1       display enable
//   vga_rgb     out  12      pixel colour, 0 when vga_de is low
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 320,
  parameter int FB_H     = 240,
  parameter int ADDR_W   = 18,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              back_buf,
  output logic              frame_start,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [11:0]       vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0]    H_LAST       = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]    H_ACT        = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]    H_SYNC_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]    H_SYNC_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]    V_LAST       = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]    V_ACT        = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]    V_SYNC_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]    V_SYNC_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] BUF_OFFSET   = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] LINE_STEP    = ADDR_W'(FB_W);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } swap_state_e;

  // ---------------------------------------------------------------------------
  // Raster counters and framebuffer line offset
  // ---------------------------------------------------------------------------
  logic [H_W-1:0]    h_q, h_d;
  logic [V_W-1:0]    v_q, v_d;
  logic [ADDR_W-1:0] line_off_q, line_off_d;

  always_comb begin
    h_d        = h_q + H_W'(1);
    v_d        = v_q;
    line_off_d = line_off_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d        = '0;
        line_off_d = '0;
      end else begin
        v_d = v_q + V_W'(1);
        // Leaving an odd line means the next line starts a new source row.
        if (v_q[0]) begin
          line_off_d = line_off_q + LINE_STEP;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch address and raw timing
  // ---------------------------------------------------------------------------
  logic front_q, front_d;
  logic active;
  logic hs_raw;
  logic vs_raw;

  assign active = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
  assign vs_raw = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
  assign rd_en  = active;

  always_comb begin
    rd_addr = '0;
    if (active) begin
      rd_addr = (front_q ? BUF_OFFSET : '0) + line_off_q + ADDR_W'(h_q[H_W-1:1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Swap FSM
  // ---------------------------------------------------------------------------
  swap_state_e state_q, state_d;
  logic        swap_req_q;
  logic        req_rise;
  logic        at_vblank;
  logic        do_swap;

  assign req_rise  = swap_req && !swap_req_q;
  assign at_vblank = (h_q == '0) && (v_q == V_ACT);

  // An edge arriving in the vblank cycle itself finds the FSM idle, so it
  // only arms and is serviced at the following frame's vblank.
  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_rise) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (at_vblank) begin
          state_d = S_IDLE;
          do_swap = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign front_d = front_q ^ do_swap;

  // ---------------------------------------------------------------------------
  // Timing delay line: sync/enable wait RD_LAT cycles for the RAM, then one
  // more in the output register together with the colour.
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0] hs_pipe_q;
  logic [RD_LAT-1:0] vs_pipe_q;
  logic [RD_LAT-1:0] de_pipe_q;

  if (RD_LAT > 1) begin : g_pipe_deep
    always_ff @(posedge clk) begin
      if (rst) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
        de_pipe_q <= '0;
      end else begin
        hs_pipe_q <= {hs_pipe_q[RD_LAT-2:0], hs_raw};
        vs_pipe_q <= {vs_pipe_q[RD_LAT-2:0], vs_raw};
        de_pipe_q <= {de_pipe_q[RD_LAT-2:0], active};
      end
    end
  end else begin : g_pipe_single
    always_ff @(posedge clk) begin
      if (rst) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
        de_pipe_q <= '0;
      end else begin
        hs_pipe_q <= hs_raw;
        vs_pipe_q <= vs_raw;
        de_pipe_q <= active;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  logic        vga_hs_q;
  logic        vga_vs_q;
  logic        vga_de_q;
  logic [11:0] vga_rgb_q;
  logic        frame_start_q;
  logic        swap_ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      line_off_q    <= '0;
      front_q       <= 1'b0;
      state_q       <= S_IDLE;
      swap_req_q    <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_de_q      <= 1'b0;
      vga_rgb_q     <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      line_off_q    <= line_off_d;
      front_q       <= front_d;
      state_q       <= state_d;
      swap_req_q    <= swap_req;
      swap_ack_q    <= do_swap;
      frame_start_q <= (h_q == '0) && (v_q == '0);
      vga_hs_q      <= hs_pipe_q[RD_LAT-1];
      vga_vs_q      <= vs_pipe_q[RD_LAT-1];
      vga_de_q      <= de_pipe_q[RD_LAT-1];
      // Gating with the delayed enable also discards data for reads that
      // were in flight when reset hit, since the enable pipe was flushed.
      vga_rgb_q     <= de_pipe_q[RD_LAT-1] ? rd_data : 12'h000;
    end
  end

  assign swap_ack    = swap_ack_q;
  assign back_buf    = ~front_q;
  assign frame_start = frame_start_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_de      = vga_de_q;
  assign vga_rgb     = vga_rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout.sv
//==============================================================================
// Module      : tb_fb_scanout
// Description : Self-checking bench for fb_scanout. A reduced-geometry
//               instance (24x12 raster, 8x4 framebuffer) exercises frames,
//               swaps and mid-frame reset; a default-geometry instance checks
//               the first lines of real 640x480 timing and addressing.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fb_scanout;

  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 2;
  localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 24
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 12

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_init = 1'b1;
  logic rst_mid  = 1'b0;
  logic rst_s;
  assign rst_s = rst_init | rst_mid;

  // small instance
  logic        s_rd_en, s_swap_req, s_swap_ack, s_back_buf, s_frame_start;
  logic        s_vga_hs, s_vga_vs, s_vga_de;
  logic [17:0] s_rd_addr;
  logic [11:0] s_rd_data, s_vga_rgb;
  // full-size instance
  logic        f_rd_en, f_swap_req, f_swap_ack, f_back_buf, f_frame_start;
  logic        f_vga_hs, f_vga_vs, f_vga_de;
  logic [17:0] f_rd_addr;
  logic [11:0] f_rd_data, f_vga_rgb;

  fb_scanout #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .FB_W(8), .FB_H(4), .ADDR_W(18), .RD_LAT(2)
  ) u_small (
    .clk(clk), .rst(rst_s), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .swap_req(s_swap_req), .swap_ack(s_swap_ack), .back_buf(s_back_buf),
    .frame_start(s_frame_start), .vga_hs(s_vga_hs), .vga_vs(s_vga_vs),
    .vga_de(s_vga_de), .vga_rgb(s_vga_rgb)
  );

  fb_scanout u_full (
    .clk(clk), .rst(rst_init), .rd_en(f_rd_en), .rd_addr(f_rd_addr), .rd_data(f_rd_data),
    .swap_req(f_swap_req), .swap_ack(f_swap_ack), .back_buf(f_back_buf),
    .frame_start(f_frame_start), .vga_hs(f_vga_hs), .vga_vs(f_vga_vs),
    .vga_de(f_vga_de), .vga_rgb(f_vga_rgb)
  );

  // RAM models: data = addr[11:0], two-cycle read latency
  logic [11:0] s_ram_q [2];
  logic [11:0] f_ram_q [2];
  always @(posedge clk) begin
    s_ram_q[0] <= s_rd_addr[11:0];
    s_ram_q[1] <= s_ram_q[0];
    f_ram_q[0] <= f_rd_addr[11:0];
    f_ram_q[1] <= f_ram_q[0];
  end
  assign s_rd_data = s_ram_q[1];
  assign f_rd_data = f_ram_q[1];

  // Raster position index: cycle n after reset holds position n (mod frame)
  int n = 0;
  always @(posedge clk) begin
    if (rst_s) n <= 0;
    else       n <= n + 1;
  end

  int errors    = 0;
  int checks    = 0;
  int mism      = 0;
  int ack_cnt   = 0;
  int f_hs_low  = 0;
  int ack_snap  = 0;
  bit mon_en    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (n=%0d t=%0t)", tag, act, exp, n, $time);
    end
  endtask

  task automatic goto(input int t);
    while (n < t) @(negedge clk);
  endtask

  // Continuous timing monitor for the small instance: outputs at cycle n
  // reflect raster position n-3; before that they hold reset values.
  always @(negedge clk) begin : mon
    int p, hp, vp;
    logic ehs, evs, ede;
    if (mon_en) begin
      if (n < 3) begin
        ehs = 1'b1; evs = 1'b1; ede = 1'b0;
      end else begin
        p   = n - 3;
        hp  = p % S_HT;
        vp  = (p / S_HT) % S_VT;
        ede = (hp < S_HA) && (vp < S_VA);
        ehs = !((hp >= S_HA + S_HF) && (hp < S_HA + S_HF + S_HS));
        evs = !((vp >= S_VA + S_VF) && (vp < S_VA + S_VF + S_VS));
      end
      if (s_vga_hs !== ehs || s_vga_vs !== evs || s_vga_de !== ede ||
          (!s_vga_de && s_vga_rgb !== 12'h000))
        mism++;
      if (s_swap_ack) ack_cnt++;
      if (n >= 3 && n <= 802 && !f_vga_hs) f_hs_low++;
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    s_swap_req = 1'b0;
    f_swap_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_init = 1'b0;
    mon_en   = 1'b1;

    // reset state (n = 0)
    chk("rst_hs", s_vga_hs, 1);
    chk("rst_vs", s_vga_vs, 1);
    chk("rst_de", s_vga_de, 0);
    chk("rst_rgb", s_vga_rgb, 0);
    chk("rst_ack", s_swap_ack, 0);
    chk("rst_fs", s_frame_start, 0);
    chk("rst_backbuf", s_back_buf, 1);
    chk("rst_full_hs", f_vga_hs, 1);

    goto(1);  chk("fs_pulse", s_frame_start, 1);
    goto(2);  chk("fs_single", s_frame_start, 0);
    goto(16); chk("addr_hblank", s_rd_addr, 0);
              chk("rden_hblank", s_rd_en, 0);
    goto(50); chk("addr_v2h2", s_rd_addr, 9);
    goto(74); chk("addr_v3h2", s_rd_addr, 9);
              chk("rden_active", s_rd_en, 1);
    goto(75); chk("addr_v3h3", s_rd_addr, 9);
    goto(77); chk("rgb_lat", s_vga_rgb, 12'h009);
              chk("de_lat", s_vga_de, 1);

    // swap requested mid-frame
    goto(100); s_swap_req = 1'b1;
    goto(192); chk("ack_early", s_swap_ack, 0);
               chk("bb_before", s_back_buf, 1);
    goto(193); chk("ack_pulse", s_swap_ack, 1);
               chk("bb_after", s_back_buf, 0);
    goto(194); chk("ack_one", s_swap_ack, 0);
    goto(200); s_swap_req = 1'b0;
    goto(288); chk("addr_front1", s_rd_addr, 32);
    goto(289); chk("fs_frame2", s_frame_start, 1);

    // edge coincident with vblank start: deferred one frame
    goto(480); chk("ack_coinc_pre", s_swap_ack, 0);
               s_swap_req = 1'b1;
    goto(481); chk("ack_coinc", s_swap_ack, 0);
               chk("bb_coinc", s_back_buf, 0);
    goto(490); s_swap_req = 1'b0;

    // full-size timing on line 0
    goto(642); chk("f_de_last", f_vga_de, 1);
    goto(643); chk("f_de_off", f_vga_de, 0);
               chk("f_rgb_off", f_vga_rgb, 0);
    goto(658); chk("f_hs_pre", f_vga_hs, 1);
    goto(659); chk("f_hs_fall", f_vga_hs, 0);
    goto(754); chk("f_hs_last", f_vga_hs, 0);
    goto(755); chk("f_hs_rise", f_vga_hs, 1);

    goto(768); chk("ack_def_pre", s_swap_ack, 0);
    goto(769); chk("ack_deferred", s_swap_ack, 1);
               chk("bb_deferred", s_back_buf, 1);
    goto(810); chk("f_hs_width", f_hs_low, 96);
    goto(864); chk("addr_front0", s_rd_addr, 0);

    // request held high across three frames
    goto(900);  ack_snap = ack_cnt; s_swap_req = 1'b1;
    goto(1764); chk("held_acks", ack_cnt - ack_snap, 1);
                s_swap_req = 1'b0;

    // two rising edges in one frame
    goto(2030); ack_snap = ack_cnt; s_swap_req = 1'b1;
    goto(2040); s_swap_req = 1'b0;
    goto(2050); s_swap_req = 1'b1;
    goto(2060); s_swap_req = 1'b0;
    goto(2209); chk("ack_double", s_swap_ack, 1);
    goto(2304); chk("double_acks", ack_cnt - ack_snap, 1);
                chk("bb_double", s_back_buf, 1);

    goto(2320); s_swap_req = 1'b1;
    goto(2400); s_swap_req = 1'b0;
    goto(2401); chk("f_addr_320", f_rd_addr, 320);
    goto(2402); chk("f_addr_321", f_rd_addr, 321);
                chk("f_rden", f_rd_en, 1);
    goto(2404); chk("f_rgb_140", f_vga_rgb, 12'h140);
    goto(2405); chk("f_rgb_141", f_vga_rgb, 12'h141);
                chk("f_de_141", f_vga_de, 1);
    goto(2497); chk("ack_pre_rst", s_swap_ack, 1);
                chk("bb_pre_rst", s_back_buf, 0);

    // arm again, then reset mid-line
    goto(2700); s_swap_req = 1'b1;
    goto(2710); s_swap_req = 1'b0;
    goto(2722); chk("de_before_rst", s_vga_de, 1);
                chk("rgb_before_rst", s_vga_rgb, 12'h033);
                rst_mid = 1'b1;
    @(negedge clk);
    chk("mrst_hs", s_vga_hs, 1);
    chk("mrst_de", s_vga_de, 0);
    chk("mrst_rgb", s_vga_rgb, 0);
    chk("mrst_fs", s_frame_start, 0);
    chk("mrst_bb", s_back_buf, 1);
    chk("mrst_addr", s_rd_addr, 0);
    rst_mid = 1'b0;
    goto(1);   chk("mrst_fs_pulse", s_frame_start, 1);
               chk("mrst_rgb_flush", s_vga_rgb, 0);
    goto(2);   chk("mrst_de_flush", s_vga_de, 0);
    goto(193); chk("mrst_no_ack", s_swap_ack, 0);
               chk("mrst_bb_hold", s_back_buf, 1);
    goto(289); chk("mrst_fs_frame2", s_frame_start, 1);

    @(posedge clk);
    @(negedge clk);
    chk("sync_monitor", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
